// File: rtl/mem_stage.sv
// Memory stage of the RV32I pipeline: word loads/stores over a req/gnt/rvalid bus.
// Optional macro MEM_MISALIGN_CHECK_EN traps misaligned accesses instead of issuing them.
package mem_stage_pkg;
    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic        mem_write;
        logic        mem_read;
        logic        reg_write;
        logic [4:0]  rd;
    } ex_to_mem_s;

    typedef struct packed {
        logic [31:0] result;
        logic        reg_write;
        logic [4:0]  rd;
    } mem_to_wb_s;
endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  ex_to_mem_s      ex_to_mem,
    input  logic            ex_valid,
    output logic            mem_stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output mem_to_wb_s      mem_to_wb,
    output logic            wb_valid,
    output logic            misalign
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]      state_reg;
    logic [XLEN-1:0] addr_reg;
    logic [XLEN-1:0] wdata_reg;
    logic [4:0]      rd_reg;
    logic            reg_write_reg;
    logic            store_reg;
    mem_to_wb_s      wb_reg;
    logic            wb_valid_reg;
    logic            misalign_reg;

    logic mem_op;
    logic is_store;
    logic misaligned;

    // Both read and write set decodes as a load.
    assign mem_op   = ex_to_mem.mem_read | ex_to_mem.mem_write;
    assign is_store = ex_to_mem.mem_write & ~ex_to_mem.mem_read;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned = (ex_to_mem.alu_result[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rd_reg        <= '0;
            reg_write_reg <= 1'b0;
            store_reg     <= 1'b0;
            wb_reg        <= '0;
            wb_valid_reg  <= 1'b0;
            misalign_reg  <= 1'b0;
        end else begin
            wb_valid_reg <= 1'b0;
            misalign_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (ex_valid) begin
                        if (mem_op) begin
                            addr_reg      <= ex_to_mem.alu_result;
                            wdata_reg     <= ex_to_mem.write_data;
                            rd_reg        <= ex_to_mem.rd;
                            reg_write_reg <= ex_to_mem.reg_write;
                            store_reg     <= is_store;
                            if (misaligned) begin
                                state_reg    <= DONE;
                                wb_reg       <= '{result: ex_to_mem.alu_result, reg_write: 1'b0, rd: ex_to_mem.rd};
                                wb_valid_reg <= 1'b1;
                                misalign_reg <= 1'b1;
                            end else begin
                                state_reg <= REQ;
                            end
                        end else begin
                            wb_reg       <= '{result: ex_to_mem.alu_result, reg_write: ex_to_mem.reg_write, rd: ex_to_mem.rd};
                            wb_valid_reg <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        if (store_reg) begin
                            state_reg    <= DONE;
                            wb_reg       <= '{result: addr_reg, reg_write: 1'b0, rd: rd_reg};
                            wb_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        state_reg    <= DONE;
                        wb_reg       <= '{result: dmem_rdata, reg_write: reg_write_reg, rd: rd_reg};
                        wb_valid_reg <= 1'b1;
                    end
                end
                default: begin
                    // DONE: ex_valid still shows the retired op, so it is not re-accepted.
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign mem_stall  = (state_reg == REQ) || (state_reg == WAIT) ||
                        ((state_reg == IDLE) && ex_valid && mem_op);
    assign dmem_req   = (state_reg == REQ);
    assign dmem_we    = store_reg;
    assign dmem_addr  = {addr_reg[XLEN-1:2], 2'b00};
    assign dmem_wdata = wdata_reg;
    assign mem_to_wb  = wb_reg;
    assign wb_valid   = wb_valid_reg;
    assign misalign   = misalign_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed literal cases, then randomized traffic
// against a queue-based retirement/memory model with a random-latency bus responder.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    ex_to_mem_s  ex;
    logic        ex_valid;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    mem_to_wb_s  mem_to_wb;
    logic        wb_valid;
    logic        misalign;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;
    bit auto_bus = 1'b0;

    typedef struct {
        logic [31:0] result;
        logic        reg_write;
        logic [4:0]  rd;
        logic        mis;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_exp_t;

    wb_exp_t     wb_q[$];
    bus_exp_t    bus_q[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] bus_mem[logic [31:0]];

    mem_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .ex_to_mem(ex), .ex_valid(ex_valid),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_to_wb(mem_to_wb), .wb_valid(wb_valid), .misalign(misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ex_to_mem_s mk(logic [31:0] a, logic [31:0] wd, logic w, logic r,
                                      logic rw, logic [4:0] rd);
        ex_to_mem_s e;
        e.alu_result = a; e.write_data = wd; e.mem_write = w;
        e.mem_read = r; e.reg_write = rw; e.rd = rd;
        return e;
    endfunction

    // Reference model: decide what the op must retire as and what bus access it needs.
    task automatic issue(ex_to_mem_s op);
        wb_exp_t  we_;
        bus_exp_t be;
        logic     memop, store, trap;
        logic [31:0] wa;
        int n;
        memop = op.mem_read | op.mem_write;
        store = op.mem_write & ~op.mem_read;
        wa    = {op.alu_result[31:2], 2'b00};
`ifdef MEM_MISALIGN_CHECK_EN
        trap = memop && (op.alu_result[1:0] != 2'b00);
`else
        trap = 1'b0;
`endif
        if (!memop) begin
            we_ = '{op.alu_result, op.reg_write, op.rd, 1'b0};
        end else if (trap) begin
            we_ = '{op.alu_result, 1'b0, op.rd, 1'b1};
        end else if (store) begin
            we_ = '{op.alu_result, 1'b0, op.rd, 1'b0};
            ref_mem[wa] = op.write_data;
            be = '{1'b1, wa, op.write_data};
            bus_q.push_back(be);
        end else begin
            we_ = '{ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa), op.reg_write, op.rd, 1'b0};
            be = '{1'b0, wa, 32'h0};
            bus_q.push_back(be);
        end
        wb_q.push_back(we_);
        ex = op;
        ex_valid = 1'b1;
        $display("issue alu=%h wd=%h w=%0b r=%0b rd=%0d", op.alu_result, op.write_data,
                 op.mem_write, op.mem_read, op.rd);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mem_stall && n < 60);
        if (mem_stall) chk("issue_timeout", 32'(mem_stall), 32'd0);
        if (memop) chk("retire_when_stall_drops", 32'(wb_valid), 32'd1);
        tick();
    endtask

    // Retirement compare against the model queue.
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (model_on && rst_n && wb_valid) begin
                if (wb_q.size() == 0) begin
                    chk("unexpected_wb_valid", 32'(wb_valid), 32'd0);
                end else begin
                    e = wb_q.pop_front();
                    chk("wb_result", mem_to_wb.result, e.result);
                    chk("wb_reg_write", 32'(mem_to_wb.reg_write), 32'(e.reg_write));
                    chk("wb_rd", 32'(mem_to_wb.rd), 32'(e.rd));
                    chk("wb_misalign", 32'(misalign), 32'(e.mis));
                end
            end
        end
    end

    // Random-latency bus responder, with stray rvalids when no load is outstanding.
    initial begin
        int gnt_wait = -1;
        int rv_wait  = -1;
        logic [31:0] pend_addr = '0;
        bus_exp_t b;
        forever begin
            @(posedge clk);
            #2;
            if (auto_bus) begin
                dmem_gnt    = 1'b0;
                dmem_rvalid = 1'b0;
                dmem_rdata  = $urandom;
                if (rv_wait == 0) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = bus_mem.exists(pend_addr) ? bus_mem[pend_addr] : init_word(pend_addr);
                    rv_wait     = -1;
                end else if (rv_wait > 0) begin
                    rv_wait--;
                end else if (dmem_req) begin
                    if (gnt_wait < 0) gnt_wait = $urandom_range(0, 3);
                    if (gnt_wait == 0) begin
                        dmem_gnt = 1'b1;
                        gnt_wait = -1;
                        if (bus_q.size() == 0) begin
                            chk("unexpected_bus_req", 32'(dmem_req), 32'd0);
                        end else begin
                            b = bus_q.pop_front();
                            chk("bus_we", 32'(dmem_we), 32'(b.we));
                            chk("bus_addr", dmem_addr, b.addr);
                            if (b.we) chk("bus_wdata", dmem_wdata, b.wdata);
                        end
                        if (dmem_we) bus_mem[dmem_addr] = dmem_wdata;
                        else begin
                            pend_addr = dmem_addr;
                            rv_wait   = $urandom_range(0, 3);
                        end
                    end else begin
                        gnt_wait--;
                    end
                end
                if (rv_wait < 0 && !dmem_gnt && !dmem_rvalid && $urandom_range(0, 7) == 0)
                    dmem_rvalid = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int req_cnt;
        rst_n = 1'b0; ex_valid = 1'b1; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        ex = mk(32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 5'd5);

        // Reset held two cycles with a live op on the input.
        tick(); tick();
        @(negedge clk);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_mem_to_wb", 32'(mem_to_wb), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        tick(); rst_n = 1'b1; ex_valid = 1'b0;

        // ALU op retires the next cycle without stalling.
        tick(); ex = mk(32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5); ex_valid = 1'b1;
        @(negedge clk); chk("alu_stall", 32'(mem_stall), 32'd0);
        tick(); ex_valid = 1'b0;
        @(negedge clk);
        chk("alu_wb_valid", 32'(wb_valid), 32'd1);
        chk("alu_result", mem_to_wb.result, 32'h10);
        chk("alu_rd", 32'(mem_to_wb.rd), 32'd5);
        chk("alu_reg_write", 32'(mem_to_wb.reg_write), 32'd1);
        tick(); @(negedge clk); chk("bubble_wb_valid", 32'(wb_valid), 32'd0);

        // Load from 0x100: grant after two waiting cycles, rvalid one cycle after grant.
        ex = mk(32'h100, 32'h0, 1'b0, 1'b1, 1'b1, 5'd7); ex_valid = 1'b1;
        @(negedge clk);
        chk("ld_accept_stall", 32'(mem_stall), 32'd1);
        req_cnt = 0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            dmem_gnt    = (c == 3);
            dmem_rvalid = (c == 4);
            dmem_rdata  = (c == 4) ? 32'hDEAD_BEEF : 32'h0;
            @(negedge clk);
            if (dmem_req) begin
                req_cnt++;
                chk("ld_addr", dmem_addr, 32'h100);
                chk("ld_we", 32'(dmem_we), 32'd0);
            end
            if (c < 5) begin
                chk("ld_stall", 32'(mem_stall), 32'd1);
                chk("ld_early_wb", 32'(wb_valid), 32'd0);
            end else begin
                chk("ld_wb_valid", 32'(wb_valid), 32'd1);
                chk("ld_result", mem_to_wb.result, 32'hDEAD_BEEF);
                chk("ld_done_stall", 32'(mem_stall), 32'd0);
            end
        end
        chk("ld_req_cycles", 32'(req_cnt), 32'd3);
        tick(); ex_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;

        // Store 0x12345678 to 0x204 with immediate grant.
        tick(); ex = mk(32'h204, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 5'd3); ex_valid = 1'b1;
        @(negedge clk); chk("st_accept_stall", 32'(mem_stall), 32'd1);
        tick(); dmem_gnt = 1'b1;
        @(negedge clk);
        chk("st_req", 32'(dmem_req), 32'd1);
        chk("st_we", 32'(dmem_we), 32'd1);
        chk("st_wdata", dmem_wdata, 32'h1234_5678);
        chk("st_addr", dmem_addr, 32'h204);
        tick(); dmem_gnt = 1'b0;
        @(negedge clk);
        chk("st_wb_valid", 32'(wb_valid), 32'd1);
        chk("st_reg_write", 32'(mem_to_wb.reg_write), 32'd0);
        chk("st_result", mem_to_wb.result, 32'h204);
        tick(); ex_valid = 1'b0;

        // Load abandoned by reset while waiting for data; the late rvalid is ignored.
        tick(); ex = mk(32'h300, 32'h0, 1'b0, 1'b1, 1'b1, 5'd4); ex_valid = 1'b1;
        tick(); dmem_gnt = 1'b1;
        tick(); dmem_gnt = 1'b0; rst_n = 1'b0; ex_valid = 1'b0;
        @(negedge clk);
        chk("rw_wait_stall", 32'(mem_stall), 32'd1);
        chk("rw_wait_req", 32'(dmem_req), 32'd0);
        tick(); rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hAAAA_AAAA;
        @(negedge clk);
        chk("rw_after_wb", 32'(wb_valid), 32'd0);
        chk("rw_after_stall", 32'(mem_stall), 32'd0);
        tick(); dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("rw_late_wb", 32'(wb_valid), 32'd0);
        chk("rw_mem_to_wb", 32'(mem_to_wb), 32'd0);

        // Misaligned load to 0x102.
        tick(); ex = mk(32'h102, 32'h0, 1'b0, 1'b1, 1'b1, 5'd9); ex_valid = 1'b1;
        @(negedge clk);
        chk("mis_accept_stall", 32'(mem_stall), 32'd1);
        chk("mis_accept_req", 32'(dmem_req), 32'd0);
`ifdef MEM_MISALIGN_CHECK_EN
        tick();
        @(negedge clk);
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_wb_valid", 32'(wb_valid), 32'd1);
        chk("mis_flag", 32'(misalign), 32'd1);
        chk("mis_reg_write", 32'(mem_to_wb.reg_write), 32'd0);
        chk("mis_stall", 32'(mem_stall), 32'd0);
        tick(); ex_valid = 1'b0;
        @(negedge clk); chk("mis_flag_clear", 32'(misalign), 32'd0);
`else
        tick(); dmem_gnt = 1'b1;
        @(negedge clk);
        chk("mis_req", 32'(dmem_req), 32'd1);
        chk("mis_addr", dmem_addr, 32'h100);
        tick(); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_0055;
        @(negedge clk); chk("mis_wait_stall", 32'(mem_stall), 32'd1);
        tick(); dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("mis_wb_valid", 32'(wb_valid), 32'd1);
        chk("mis_result", mem_to_wb.result, 32'h0000_0055);
        chk("mis_reg_write", 32'(mem_to_wb.reg_write), 32'd1);
        chk("mis_flag", 32'(misalign), 32'd0);
        tick(); ex_valid = 1'b0;
`endif

        // Randomized traffic against the model.
        tick(); tick();
        auto_bus = 1'b1;
        model_on = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int kind;
            logic [31:0] a;
            kind = $urandom_range(0, 4);
            a = 32'h1000 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            if (kind == 0) begin
                ex_valid = 1'b0;
                tick();
            end else if (kind == 1) begin
                issue(mk($urandom, $urandom, 1'b0, 1'b0, 1'($urandom), 5'($urandom)));
            end else if (kind == 2) begin
                issue(mk(a, $urandom, 1'b1, 1'b0, 1'($urandom), 5'($urandom)));
            end else begin
                if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
                issue(mk(a, $urandom, 1'b0, 1'b1, 1'b1, 5'($urandom)) |
                      ((kind == 4 && $urandom_range(0, 2) == 0) ? mk(32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0)
                                                               : mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0)));
            end
        end
        ex_valid = 1'b0;
        repeat (4) tick();
        chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the in-order RV32I pipeline, sitting between `execute` and writeback. It consumes the registered `ex_to_mem_s` bundle and performs word loads and stores on a data-memory bus with a request/grant/response handshake. It stalls upstream while an access is outstanding and delivers a registered `mem_to_wb_s` bundle with a one-cycle valid strobe per retired instruction.

## Interface
Parameters:
- `XLEN`, 32, data and address width.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `ex_to_mem`  in  `ex_to_mem_s`  fields `alu_result`, `write_data`, `mem_write`, `mem_read`, `reg_write`, `rd`.
- `ex_valid`  in  1  `ex_to_mem` holds a live instruction.
- `mem_stall`  out  1  combinational; upstream must hold `ex_to_mem`/`ex_valid` while high.
- `dmem_req`  out  1  bus request; held until `dmem_gnt`.
- `dmem_we`  out  1  1 = store, 0 = load.
- `dmem_addr`  out  XLEN  word-aligned byte address.
- `dmem_wdata`  out  XLEN  store data.
- `dmem_gnt`  in  1  request accepted this cycle.
- `dmem_rvalid`  in  1  load data valid.
- `dmem_rdata`  in  XLEN  load data.
- `mem_to_wb`  out  `mem_to_wb_s`  fields `result[31:0]`, `reg_write`, `rd[4:0]`; registered.
- `wb_valid`  out  1  one-cycle strobe: `mem_to_wb` is new.
- `misalign`  out  1  registered; set with `wb_valid` for a misaligned access (macro-dependent).

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, `ex_valid`=0: `wb_valid`←0.
- IDLE, `ex_valid`=1, no mem op: `mem_to_wb`←{`alu_result`, `reg_write`, `rd`}, `wb_valid`←1, stay IDLE, `mem_stall`=0.
- IDLE, `ex_valid`=1, mem op (`mem_read` or `mem_write`): latch address, write data, `rd`, `reg_write`, and op type. Go to REQ. `mem_stall`=1 combinationally in this cycle.
- `mem_read`=`mem_write`=1 is treated as a load.
- REQ: `dmem_req`=1, with `dmem_we`, `dmem_addr`, and `dmem_wdata` from the latch and stable until grant.
  - `dmem_gnt`=1 on a store → DONE.
  - `dmem_gnt`=1 on a load → WAIT.
- WAIT: `dmem_req`=0. On `dmem_rvalid`: `result`←`dmem_rdata` → DONE. `dmem_rvalid` is only sampled in WAIT and is ignored in every other state.
- Entry into DONE writes `mem_to_wb`:
  - load: `result`=rdata, `reg_write`=latched value.
  - store: `result`=address, `reg_write`=0.
  - `wb_valid`←1 for exactly that cycle.
- DONE: `mem_stall`=0, so upstream advances at the end of this cycle. `ex_valid` is ignored because it still shows the completed op. Next state IDLE.
- `mem_stall` = (state ∈ {REQ, WAIT}) or (state = IDLE and `ex_valid` and mem op).
- `wb_valid`=0 in every cycle in which no instruction retires (bubble).
- `dmem_addr` = {latched `alu_result[31:2]`, 2'b00}.

## Timing
- Non-memory op: accepted at edge T, `wb_valid` high in cycle T+1, no stall.
- Load with same-cycle grant and next-cycle rvalid:
  - cycle 0: accept;
  - cycle 1: REQ, `dmem_req`=1, gnt;
  - cycle 2: WAIT, rvalid;
  - cycle 3: DONE, `wb_valid`=1.
  - Next op is accepted in cycle 4.
- Store with immediate grant: `wb_valid` in cycle 2. Each extra cycle without grant or rvalid adds one cycle.
- Reset (`rst_n`=0 at an edge): state→IDLE, `dmem_req`=0 from the following cycle, `mem_to_wb`=0, `wb_valid`=0, `misalign`=0, latch cleared. An outstanding load is abandoned and its late `dmem_rvalid` is ignored.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined:
  - A mem op with `alu_result[1:0]`≠0 in IDLE issues no bus request and goes directly to DONE.
  - In DONE, `wb_valid`=1 with `reg_write` forced to 0 and `misalign`=1 for that cycle.
  - `mem_stall` is high only in the accept cycle.
- Not defined: the low two address bits are silently dropped, the access proceeds normally, and `misalign` is tied to 0.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `ex_valid`=1 → `wb_valid`=0, `dmem_req`=0, `mem_to_wb`=0.
- ALU op `alu_result`=0x0000_0010, `rd`=5, `reg_write`=1 → next cycle `wb_valid`=1, `result`=0x10, `rd`=5, never stalls.
- Load from 0x100, gnt delayed 2 cycles, rvalid 1 cycle after gnt, rdata=0xDEADBEEF:
  - `dmem_req` high 3 cycles at addr 0x100, `dmem_we`=0;
  - `mem_stall` high from accept through WAIT;
  - `wb_valid` with `result`=0xDEADBEEF.
- Store of 0x1234_5678 to 0x204, immediate gnt → `dmem_we`=1, `dmem_wdata`=0x12345678, `wb_valid` in cycle 2 with `reg_write`=0.
- Load issued, `rst_n`=0 asserted in WAIT, then rvalid with 0xAAAA_AAAA → state IDLE, no `wb_valid`, rdata discarded.
- Load to 0x102:
  - with macro: no `dmem_req`, `misalign`=1, `reg_write`=0;
  - without macro: `dmem_addr`=0x100, normal completion.
